// File: rtl/fir_result_buffer_if.sv
// Consumer-side valid/ready bundle of the FIR result buffer.
// The buffer drives valid/data (master); the consumer drives ready.
interface fir_result_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fir_result_buffer.sv
// FIR result buffer: captures results as 16-bit magnitudes into a FIFO.
// Optional macro FIR_SATURATE_EN: clamp abs(-65536) to 16'hFFFF.
module fir_result_buffer #(
  parameter int DEPTH        = 4,
  parameter int SAMPLE_LIMIT = 1000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cnt_up,
  input  logic                  clear,
  input  logic                  modwait,
  input  logic                  err,
  input  logic [16:0]           outreg_data,
  fir_result_buffer_if.master   out_if,
  output logic                  one_k_samples,
  output logic                  overrun,
  output logic                  dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
  localparam logic [15:0] LIM = 16'(SAMPLE_LIMIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  logic [0:0]    r_state;
  logic          r_mw_q;
  logic [15:0]   r_count;
  logic          r_overrun;
  logic          r_dropped;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  logic          w_fall;
  logic          w_armed;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic [16:0]   w_abs;
  logic [15:0]   w_mag;

  assign w_fall  = r_mw_q & ~modwait;
  assign w_armed = (r_state == S_ARMED);
  assign w_push  = w_armed & w_fall & ~err & ~clear;
  assign w_full  = (r_cnt == FULLV);
  assign w_empty = (r_cnt == '0);
  assign w_pop   = ~w_empty & out_if.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = w_push & (~w_full | w_pop);

  // Magnitude of the 17-bit signed result; -65536 becomes 17'h10000.
  assign w_abs = outreg_data[16] ? (~outreg_data + 17'd1) : outreg_data;

`ifdef FIR_SATURATE_EN
  assign w_mag = w_abs[16] ? 16'hFFFF : w_abs[15:0];
`else
  assign w_mag = w_abs[15:0];
`endif

  assign out_if.out_valid = ~w_empty;
  assign out_if.out_data  = w_empty ? 16'h0000 : r_mem[r_rptr];
  assign one_k_samples    = (r_count == LIM);
  assign overrun          = r_overrun;
  assign dropped          = r_dropped;

  // Delay modwait to detect the end of a computation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_mw_q <= 1'b0;
    else        r_mw_q <= modwait;
  end

  // Capture FSM and the dropped flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_dropped <= 1'b0;
    end else if (clear) begin
      r_state   <= S_IDLE;
      r_dropped <= 1'b0;
    end else begin
      unique case (1'b1)
        (w_armed & err): begin
          r_state   <= S_IDLE;
          r_dropped <= 1'b1;
        end
        (w_armed & w_fall): r_state <= cnt_up ? S_ARMED : S_IDLE;
        cnt_up:             r_state <= S_ARMED;
        default:            r_state <= r_state;
      endcase
    end
  end

  // FIFO storage; contents need no reset, the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= w_mag;
  end

  // FIFO pointers, occupancy and the overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (clear)
        r_overrun <= 1'b0;
      else if (w_push & ~w_do_push)
        r_overrun <= 1'b1;
    end
  end

  // Sample counter; wraps to 1 after reaching the limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (cnt_up)
      r_count <= (r_count == LIM) ? 16'd1 : r_count + 16'd1;
  end

endmodule

// File: tb/tb_fir_result_buffer.sv
// Directed bench for fir_result_buffer: vector table plus corner sequences.
// Define FIR_SATURATE_EN for both RTL and bench to check the clamped build.
module tb_fir_result_buffer;

  logic        clk;
  logic        n_rst;
  logic        cnt_up;
  logic        clear;
  logic        modwait;
  logic        err;
  logic [16:0] outreg_data;
  logic        one_k_samples;
  logic        overrun;
  logic        dropped;

  fir_result_buffer_if u_if();

  fir_result_buffer #(.DEPTH(4), .SAMPLE_LIMIT(1000)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cnt_up        (cnt_up),
    .clear         (clear),
    .modwait       (modwait),
    .err           (err),
    .outreg_data   (outreg_data),
    .out_if        (u_if.master),
    .one_k_samples (one_k_samples),
    .overrun       (overrun),
    .dropped       (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One computation: arm, busy for n cycles, then finish with data.
  task automatic capture(logic [16:0] d, int n, logic pop_at_push);
    cnt_up = 1'b1;
    tick();
    cnt_up  = 1'b0;
    modwait = 1'b1;
    repeat (n) tick();
    modwait     = 1'b0;
    outreg_data = d;
    u_if.out_ready = pop_at_push;
    tick();
    u_if.out_ready = 1'b0;
  endtask

  task automatic pop();
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
  endtask

  task automatic pulses(int n);
    for (int i = 0; i < n; i++) begin
      cnt_up = 1'b1;
      tick();
      cnt_up = 1'b0;
      tick();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [15:0] fill_exp[5];

  initial begin
    vecs[0] = '{17'h1FF38, 16'd200};
    vecs[1] = '{17'h00000, 16'h0000};
    vecs[2] = '{17'h00001, 16'h0001};
    vecs[3] = '{17'h1FFFF, 16'h0001};
    vecs[4] = '{17'h0FFFF, 16'hFFFF};
    vecs[5] = '{17'h10001, 16'hFFFF};
`ifdef FIR_SATURATE_EN
    vecs[6] = '{17'h10000, 16'hFFFF};
`else
    vecs[6] = '{17'h10000, 16'h0000};
`endif
    vecs[7] = '{17'h07FFF, 16'h7FFF};
    vecs[8] = '{17'h18000, 16'h8000};

    n_rst = 1'b0;
    cnt_up = 1'b0;
    clear = 1'b0;
    modwait = 1'b0;
    err = 1'b0;
    outreg_data = '0;
    u_if.out_ready = 1'b0;
    repeat (2) tick();

    chk("rst_valid", 32'(u_if.out_valid), 0);
    chk("rst_data", 32'(u_if.out_data), 0);
    chk("rst_onek", 32'(one_k_samples), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_dropped", 32'(dropped), 0);
    n_rst = 1'b1;
    tick();

    // Magnitude vectors, each captured after a 14-cycle computation.
    for (int i = 0; i < 9; i++) begin
      capture(vecs[i].din, 14, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(u_if.out_valid), 1);
      chk($sformatf("vec%0d_data", i), 32'(u_if.out_data), 32'(vecs[i].exp));
      pop();
      chk($sformatf("vec%0d_empty", i), 32'(u_if.out_valid), 0);
    end

    // Load sequence: modwait toggles without cnt_up, nothing captured.
    for (int i = 0; i < 4; i++) begin
      modwait = 1'b1;
      tick();
      modwait = 1'b0;
      outreg_data = 17'h00123;
      tick();
      chk($sformatf("load%0d_valid", i), 32'(u_if.out_valid), 0);
    end

    // Overflow: five results, no consumer.
    for (int i = 0; i < 5; i++) begin
      fill_exp[i] = 16'(10 * (i + 1));
      capture(17'(-(10 * (i + 1))), 3, 1'b0);
      if (i == 3) chk("fill4_overrun", 32'(overrun), 0);
    end
    chk("ovf_overrun", 32'(overrun), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_head%0d", i), 32'(u_if.out_data),
          32'(fill_exp[i]));
      pop();
    end
    chk("ovf_drained_valid", 32'(u_if.out_valid), 0);
    chk("ovf_drained_data", 32'(u_if.out_data), 0);
    chk("ovf_sticky", 32'(overrun), 1);
    do_clear();
    chk("clr_overrun", 32'(overrun), 0);

    // Full FIFO with simultaneous push and pop: no loss, no overrun.
    for (int i = 0; i < 4; i++) capture(17'(i + 1), 2, 1'b0);
    capture(17'd5, 2, 1'b1);
    chk("pp_overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_head%0d", i), 32'(u_if.out_data), 32'(i + 2));
      pop();
    end
    chk("pp_empty", 32'(u_if.out_valid), 0);

    // Sample counter limit and wrap.
    do_clear();
    pulses(999);
    chk("cnt999", 32'(one_k_samples), 0);
    pulses(1);
    chk("cnt1000", 32'(one_k_samples), 1);
    repeat (5) tick();
    chk("cnt1000_hold", 32'(one_k_samples), 1);
    pulses(1);
    chk("cnt1001", 32'(one_k_samples), 0);
    pulses(998);
    chk("cnt_wrap999", 32'(one_k_samples), 0);
    pulses(1);
    chk("cnt_wrap1000", 32'(one_k_samples), 1);
    do_clear();
    chk("cnt_clear", 32'(one_k_samples), 0);
    cnt_up = 1'b1;
    clear  = 1'b1;
    tick();
    cnt_up = 1'b0;
    clear  = 1'b0;
    pulses(999);
    chk("clr_wins999", 32'(one_k_samples), 0);
    pulses(1);
    chk("clr_wins1000", 32'(one_k_samples), 1);
    do_clear();

    // Error while armed: dropped, no push.
    cnt_up = 1'b1;
    tick();
    cnt_up  = 1'b0;
    modwait = 1'b1;
    repeat (2) tick();
    err = 1'b1;
    tick();
    err = 1'b0;
    modwait = 1'b0;
    outreg_data = 17'h00055;
    tick();
    tick();
    chk("err_dropped", 32'(dropped), 1);
    chk("err_nopush", 32'(u_if.out_valid), 0);
    do_clear();
    chk("err_clear", 32'(dropped), 0);

    // Reset in the middle of a computation.
    capture(17'h00042, 2, 1'b0);
    chk("pre_rst_valid", 32'(u_if.out_valid), 1);
    cnt_up = 1'b1;
    tick();
    cnt_up  = 1'b0;
    modwait = 1'b1;
    tick();
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(u_if.out_valid), 0);
    chk("midrst_data", 32'(u_if.out_data), 0);
    chk("midrst_onek", 32'(one_k_samples), 0);
    tick();
    n_rst = 1'b1;
    tick();
    modwait = 1'b0;
    outreg_data = 17'h00077;
    tick();
    tick();
    chk("postrst_nopush", 32'(u_if.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
